// File: rtl/raster_scheduler.sv
// Triangle dispatch controller: queues setup records, culls degenerate ones,
// presents one triangle at a time to the rasterizer and keeps statistics.
package raster_pkg;
  typedef struct packed {
    logic       valid;
    logic [7:0] tri_id;
    logic [9:0] min_x;
    logic [9:0] min_y;
    logic [9:0] max_x;
    logic [9:0] max_y;
  } triangle_setup_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } ras_state_e;
endpackage

// Handshake: a record is pushed on the cycle in_valid && in_ready; the
// rasterizer accepts a triangle on the cycle ras_start && !ras_busy.
module raster_scheduler
  import raster_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  triangle_setup_t in_tri,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output triangle_setup_t ras_tri,
  output logic            ras_start,
  input  logic            ras_busy,
  input  logic            ras_done,
  input  logic            ras_frag_valid,
  input  logic            ras_frag_ready,
  input  logic            clear_stats,
  output logic            idle,
  output logic [CNT_W-1:0] tri_count,
  output logic [CNT_W-1:0] frag_count,
  output logic [CNT_W-1:0] cull_count,
  output ras_state_e      dbg_state_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  triangle_setup_t mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  ras_state_e       state_q, state_d;
  triangle_setup_t  ras_tri_q;
  logic [CNT_W-1:0] tri_cnt_q, frag_cnt_q, cull_cnt_q;

  logic            empty, full, push, pop;
  logic            cull, load, cull_inc, done_inc;
  triangle_setup_t head;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && !empty && !flush;
  assign head     = mem_q[rd_ptr_q];
  // A record with no valid flag or an inverted bbox produces no fragments.
  assign cull     = !head.valid || (head.min_x > head.max_x) || (head.min_y > head.max_y);

  // Storage array: written on push only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_tri;
  end

  // Occupancy next value from push/pop.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers; flush drops everything queued by catching up the read side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Dispatch FSM next-state and strobes.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    cull_inc = 1'b0;
    done_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (cull) begin
            cull_inc = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        if (!ras_busy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ras_done) begin
          done_inc = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Active triangle register, held through start and rasterization.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ras_tri_q <= '0;
    else if (load) ras_tri_q <= head;
  end

  // Statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tri_cnt_q  <= '0;
      frag_cnt_q <= '0;
      cull_cnt_q <= '0;
    end else if (clear_stats) begin
      tri_cnt_q  <= '0;
      frag_cnt_q <= '0;
      cull_cnt_q <= '0;
    end else begin
      if (done_inc) tri_cnt_q <= tri_cnt_q + 1'b1;
      if (ras_frag_valid && ras_frag_ready) frag_cnt_q <= frag_cnt_q + 1'b1;
      if (cull_inc) cull_cnt_q <= cull_cnt_q + 1'b1;
    end
  end

  assign ras_tri     = ras_tri_q;
  assign ras_start   = (state_q == S_START);
  assign idle        = (state_q == S_IDLE) && empty;
  assign tri_count   = tri_cnt_q;
  assign frag_count  = frag_cnt_q;
  assign cull_count  = cull_cnt_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_raster_scheduler.sv
// Directed bench for raster_scheduler: the rasterizer side is driven by hand,
// with ras_busy held high whenever the model is not ready for a new triangle.
module tb_raster_scheduler;
  import raster_pkg::*;

  localparam int CNT_W = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  triangle_setup_t in_tri;
  logic            in_valid, in_ready, flush;
  triangle_setup_t ras_tri;
  logic            ras_start, ras_busy, ras_done;
  logic            ras_frag_valid, ras_frag_ready, clear_stats, idle;
  logic [CNT_W-1:0] tri_count, frag_count, cull_count;
  ras_state_e      dbg_state;

  int checks = 0;
  int errors = 0;
  triangle_setup_t tl [6];

  raster_scheduler #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_tri(in_tri), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .ras_tri(ras_tri), .ras_start(ras_start),
    .ras_busy(ras_busy), .ras_done(ras_done), .ras_frag_valid(ras_frag_valid),
    .ras_frag_ready(ras_frag_ready), .clear_stats(clear_stats), .idle(idle),
    .tri_count(tri_count), .frag_count(frag_count), .cull_count(cull_count),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic triangle_setup_t mk(input int id, input int x0, input int y0,
                                         input int x1, input int y1, input bit v);
    triangle_setup_t t;
    t.valid  = v;
    t.tri_id = 8'(id);
    t.min_x  = 10'(x0);
    t.min_y  = 10'(y0);
    t.max_x  = 10'(x1);
    t.max_y  = 10'(y1);
    return t;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    cyc(); clear_stats = 1'b1;
    cyc(); clear_stats = 1'b0;
  endtask

  // Waits for ras_start, holds busy for `hold` cycles, accepts, rasterizes
  // for `lat` cycles, pulses done. Returns one cycle after the done pulse.
  task automatic dispatch(input triangle_setup_t exp_t, input int hold, input int lat);
    int k = 0;
    while (!ras_start && k < 20) begin
      cyc(); settle(); k++;
    end
    chk("start_seen", 64'(ras_start), 64'd1);
    chk("start_tri", 64'(ras_tri), 64'(exp_t));
    for (int h = 0; h < hold; h++) begin
      cyc(); settle();
      chk("hold_start", 64'(ras_start), 64'd1);
      chk("hold_state", 64'(dbg_state), 64'(S_START));
    end
    cyc(); ras_busy = 1'b0; settle();
    chk("accept_start", 64'(ras_start), 64'd1);
    cyc(); ras_busy = 1'b1; settle();
    chk("wait_state", 64'(dbg_state), 64'(S_WAIT));
    chk("wait_nostart", 64'(ras_start), 64'd0);
    for (int l = 0; l < lat; l++) begin
      cyc(); settle();
      chk("tri_stable", 64'(ras_tri), 64'(exp_t));
    end
    cyc(); ras_done = 1'b1; settle();
    cyc(); ras_done = 1'b0; settle();
    chk("back_idle", 64'(dbg_state), 64'(S_IDLE));
  endtask

  initial begin
    in_tri = '0; in_valid = 1'b0; flush = 1'b0; ras_busy = 1'b1; ras_done = 1'b0;
    ras_frag_valid = 1'b0; ras_frag_ready = 1'b0; clear_stats = 1'b0;
    for (int i = 0; i < 6; i++) tl[i] = mk(i + 1, i, i, i + 3, i + 4, 1'b1);

    // Reset values
    #2 rst_n = 1'b0;
    settle();
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_start", 64'(ras_start), 64'd0);
    chk("rst_tri", 64'(ras_tri), 64'd0);
    chk("rst_tricnt", 64'(tri_count), 64'd0);
    cyc(); rst_n = 1'b1;
    cyc();

    // 1: single triangle, start at N+2, stable for 20 cycles
    in_tri = mk(9, 0, 0, 3, 3, 1'b1);
    in_valid = 1'b1; settle();
    chk("t1_ready", 64'(in_ready), 64'd1);
    cyc(); in_valid = 1'b0; settle();
    chk("t1_n1_start", 64'(ras_start), 64'd0);
    chk("t1_n1_idle", 64'(idle), 64'd0);
    cyc(); settle();
    chk("t1_n2_start", 64'(ras_start), 64'd1);
    dispatch(mk(9, 0, 0, 3, 3, 1'b1), 0, 20);
    chk("t1_tricnt", 64'(tri_count), 64'd1);
    chk("t1_idle", 64'(idle), 64'd1);

    // 2: six back-to-back pushes against a busy rasterizer
    clear();
    for (int i = 0; i < 5; i++) begin
      cyc(); in_valid = 1'b1; in_tri = tl[i]; settle();
      chk("t2_ready_open", 64'(in_ready), 64'd1);
    end
    cyc(); in_tri = tl[5]; settle();
    chk("t2_ready_full", 64'(in_ready), 64'd0);
    cyc(); in_valid = 1'b0; settle();
    chk("t2_ready_full2", 64'(in_ready), 64'd0);
    dispatch(tl[0], 0, 3);
    cyc(); in_valid = 1'b1; in_tri = tl[5]; settle();
    chk("t2_b2b_start", 64'(ras_start), 64'd1);
    chk("t2_ready_reopen", 64'(in_ready), 64'd1);
    cyc(); in_valid = 1'b0;
    for (int i = 1; i < 6; i++) dispatch(tl[i], 0, 2);
    chk("t2_tricnt", 64'(tri_count), 64'd6);
    chk("t2_idle", 64'(idle), 64'd1);

    // 3: culled records, then a one-pixel bbox that must dispatch
    clear();
    cyc(); in_valid = 1'b1; in_tri = mk(20, 5, 0, 4, 3, 1'b1);
    cyc(); in_tri = mk(21, 0, 0, 3, 3, 1'b0);
    cyc(); in_tri = mk(22, 0, 6, 3, 5, 1'b1);
    cyc(); in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t3_nostart", 64'(ras_start), 64'd0);
      cyc();
    end
    settle();
    chk("t3_cullcnt", 64'(cull_count), 64'd3);
    chk("t3_tricnt", 64'(tri_count), 64'd0);
    chk("t3_idle", 64'(idle), 64'd1);
    cyc(); in_valid = 1'b1; in_tri = mk(23, 7, 7, 7, 7, 1'b1);
    cyc(); in_valid = 1'b0;
    dispatch(mk(23, 7, 7, 7, 7, 1'b1), 0, 1);
    chk("t3_pixel_cnt", 64'(tri_count), 64'd1);
    chk("t3_cull_keep", 64'(cull_count), 64'd3);

    // 4: flush with 3 queued and 1 in flight; push during flush is dropped
    clear();
    for (int i = 0; i < 4; i++) begin
      cyc(); in_valid = 1'b1; in_tri = tl[i];
    end
    cyc(); flush = 1'b1; in_tri = tl[4]; settle();
    chk("t4_flush_ready", 64'(in_ready), 64'd0);
    cyc(); flush = 1'b0; in_valid = 1'b0; settle();
    chk("t4_inflight", 64'(ras_tri), 64'(tl[0]));
    dispatch(tl[0], 0, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk("t4_nostart", 64'(ras_start), 64'd0);
    end
    chk("t4_tricnt", 64'(tri_count), 64'd1);
    chk("t4_idle", 64'(idle), 64'd1);

    // done pulse outside S_WAIT is ignored
    cyc(); ras_done = 1'b1;
    cyc(); ras_done = 1'b0; settle();
    chk("stray_done", 64'(tri_count), 64'd1);

    // 5: fragment handshakes with ready toggling, then clear vs increment
    clear();
    for (int i = 0; i < 20; i++) begin
      cyc(); ras_frag_valid = 1'b1; ras_frag_ready = (i % 2 == 1);
    end
    cyc(); ras_frag_valid = 1'b0; ras_frag_ready = 1'b1;
    cyc(); ras_frag_ready = 1'b0; settle();
    chk("t5_fragcnt", 64'(frag_count), 64'd10);
    cyc(); ras_frag_valid = 1'b1; ras_frag_ready = 1'b1; clear_stats = 1'b1;
    cyc(); ras_frag_valid = 1'b0; ras_frag_ready = 1'b0; clear_stats = 1'b0; settle();
    chk("t5_clear_prio", 64'(frag_count), 64'd0);

    // 6: busy held in S_START for 5 cycles
    cyc(); in_valid = 1'b1; in_tri = tl[2];
    cyc(); in_valid = 1'b0;
    dispatch(tl[2], 5, 2);
    chk("t6_tricnt", 64'(tri_count), 64'd1);

    // Reset in the middle of a dispatch
    cyc(); in_valid = 1'b1; in_tri = tl[3];
    cyc(); in_valid = 1'b0;
    cyc(); settle();
    chk("mr_start_pre", 64'(ras_start), 64'd1);
    cyc(); rst_n = 1'b0; #1;
    chk("mr_start", 64'(ras_start), 64'd0);
    chk("mr_tri", 64'(ras_tri), 64'd0);
    chk("mr_idle", 64'(idle), 64'd1);
    chk("mr_tricnt", 64'(tri_count), 64'd0);
    cyc(); rst_n = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
